// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives a two-input gate block through all four input
// vectors, compares its seven outputs against expected values and reports a
// sticky fail vector, a saturating mismatch count and a pass flag.
// Optional feature macro: GATE_CHK_FIRST_FAIL_EN adds first_fail_valid and
// first_fail_idx, which record the vector index of the first mismatching sample.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
`ifdef GATE_CHK_FIRST_FAIL_EN
  output logic [6:0]       fail_vec,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_idx
`else
  output logic [6:0]       fail_vec
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  // Sum is wide enough for the counter plus a full 7-bit popcount.
  localparam int unsigned SumW = ((ERR_W > 3) ? ERR_W : 3) + 1;
  localparam logic [SumW-1:0] MaxErr = SumW'((64'd1 << ERR_W) - 64'd1);
  localparam logic [3:0] Reload = 4'(SETTLE_CYCLES - 1);

  state_e           r_state, w_state_nxt;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic             r_a, w_a_nxt;
  logic             r_b, w_b_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [6:0]       r_fail, w_fail_nxt;
  logic             r_ff_valid, w_ff_valid_nxt;
  logic [1:0]       r_ff_idx, w_ff_idx_nxt;

  logic [6:0]       w_expected;
  logic [6:0]       w_mismatch;
  logic [2:0]       w_pop;
  logic [SumW-1:0]  w_sum;
  logic [ERR_W-1:0] w_err_sat;
  logic [1:0]       w_idx_inc;

  // Expected gate outputs {and, or, not_a, nand, nor, xor, xnor} per vector.
  always_comb begin
    w_expected = 7'h1D;
    unique case (r_idx)
      2'd0: w_expected = 7'h1D;
      2'd1: w_expected = 7'h3A;
      2'd2: w_expected = 7'h2A;
      2'd3: w_expected = 7'h61;
      default: w_expected = 7'h1D;
    endcase
  end

  // Per-bit mismatch, its popcount and the saturated running error total.
  always_comb begin
    w_mismatch = gate_in ^ w_expected;
    w_pop      = '0;
    for (int i = 0; i < 7; i++) begin
      w_pop = w_pop + 3'(w_mismatch[i]);
    end
    w_sum     = SumW'(r_err) + SumW'(w_pop);
    w_err_sat = (w_sum > MaxErr) ? ERR_W'(MaxErr) : ERR_W'(w_sum);
    w_idx_inc = r_idx + 2'd1;
  end

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_done_nxt     = 1'b0;
    w_pass_nxt     = r_pass;
    w_err_nxt      = r_err;
    w_fail_nxt     = r_fail;
    w_ff_valid_nxt = r_ff_valid;
    w_ff_idx_nxt   = r_ff_idx;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_err_nxt      = '0;
          w_fail_nxt     = '0;
          w_pass_nxt     = 1'b0;
          w_idx_nxt      = 2'd0;
          w_a_nxt        = 1'b0;
          w_b_nxt        = 1'b0;
          w_cnt_nxt      = Reload;
          w_ff_valid_nxt = 1'b0;
          w_ff_idx_nxt   = 2'd0;
          w_state_nxt    = StSettle;
        end
      end
      StSettle: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StSample;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      StSample: begin
        w_fail_nxt = r_fail | w_mismatch;
        w_err_nxt  = w_err_sat;
        // Only the first mismatching vector of a run is captured.
        if ((w_mismatch != 7'h00) && !r_ff_valid) begin
          w_ff_valid_nxt = 1'b1;
          w_ff_idx_nxt   = r_idx;
        end
        if (r_idx == 2'd3) begin
          w_state_nxt = StDone;
        end else begin
          w_idx_nxt   = w_idx_inc;
          w_a_nxt     = w_idx_inc[1];
          w_b_nxt     = w_idx_inc[0];
          w_cnt_nxt   = Reload;
          w_state_nxt = StSettle;
        end
      end
      StDone: begin
        w_done_nxt  = 1'b1;
        w_pass_nxt  = (r_err == '0) && (r_fail == 7'h00);
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and result registers; reset discards any partial run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_idx      <= 2'd0;
      r_cnt      <= 4'd0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= '0;
      r_fail     <= 7'h00;
      r_ff_valid <= 1'b0;
      r_ff_idx   <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_err      <= w_err_nxt;
      r_fail     <= w_fail_nxt;
      r_ff_valid <= w_ff_valid_nxt;
      r_ff_idx   <= w_ff_idx_nxt;
    end
  end

  assign a_out     = r_a;
  assign b_out     = r_b;
  assign busy      = (r_state == StSettle) || (r_state == StSample);
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail;

`ifdef GATE_CHK_FIRST_FAIL_EN
  assign first_fail_valid = r_ff_valid;
  assign first_fail_idx   = r_ff_idx;
`else
  // Capture logic is trimmed when the outputs are absent.
  logic w_ff_unused;
  assign w_ff_unused = ^{r_ff_valid, r_ff_idx};
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed bench for gate_truth_checker: a behavioural gate model with
// selectable faults feeds the main instance; a second instance with ERR_W=3
// checks counter saturation.
module tb_gate_truth_checker;

  localparam int unsigned Settle  = 2;
  localparam int          DoneCyc = 4 * (Settle + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a_out, b_out, busy, done, pass;
  logic [6:0] gate_in;
  logic [4:0] err_count;
  logic [6:0] fail_vec;
  int         mode = 0;

  logic       start3 = 1'b0;
  logic       a3, b3, busy3, done3, pass3;
  logic [2:0] err3;
  logic [6:0] fail3;

`ifdef GATE_CHK_FIRST_FAIL_EN
  logic       ff_valid, ff_valid3;
  logic [1:0] ff_idx, ff_idx3;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Behavioural gate block with optional fault injection.
  always_comb begin
    gate_in = {a_out & b_out, a_out | b_out, ~a_out, ~(a_out & b_out),
               ~(a_out | b_out), a_out ^ b_out, ~(a_out ^ b_out)};
    case (mode)
      1: gate_in[1] = 1'b0;
      2: gate_in = 7'h00;
      3: gate_in[3] = 1'b1;
      default: ;
    endcase
  end

  gate_truth_checker #(.SETTLE_CYCLES(Settle), .ERR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .gate_in   (gate_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .fail_vec         (fail_vec),
    .first_fail_valid (ff_valid),
    .first_fail_idx   (ff_idx)
`else
    .fail_vec  (fail_vec)
`endif
  );

  gate_truth_checker #(.SETTLE_CYCLES(Settle), .ERR_W(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start3),
    .a_out     (a3),
    .b_out     (b3),
    .gate_in   (7'h00),
    .busy      (busy3),
    .done      (done3),
    .pass      (pass3),
    .err_count (err3),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .fail_vec         (fail3),
    .first_fail_valid (ff_valid3),
    .first_fail_idx   (ff_idx3)
`else
    .fail_vec  (fail3)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Start a run at edge T, follow it for 20 cycles and record done timing.
  task automatic run_check(input string tag, input bit repulse,
                           output int done_cyc, output int n_done);
    done_cyc = -1;
    n_done   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, ":busy"}, 32'(busy), 32'd1);
    for (int c = 1; c <= 20; c++) begin
      if (repulse && c == 5) start = 1'b1;
      @(posedge clk);
      #1;
      if (repulse && c == 5) start = 1'b0;
      if ((c % 3 == 1) && (c <= 10))
        check_eq({tag, ":ab"}, 32'({a_out, b_out}), 32'((c - 1) / 3));
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
  endtask

  task automatic check_result(input string tag, input bit repulse, input logic exp_pass,
                              input int exp_err, input logic [6:0] exp_fail);
    int dc, nd;
    run_check(tag, repulse, dc, nd);
    check_eq({tag, ":done_cyc"}, 32'(dc), 32'(DoneCyc));
    check_eq({tag, ":n_done"}, 32'(nd), 32'd1);
    check_eq({tag, ":pass"}, 32'(pass), 32'(exp_pass));
    check_eq({tag, ":err"}, 32'(err_count), 32'(exp_err));
    check_eq({tag, ":fail"}, 32'(fail_vec), 32'(exp_fail));
    check_eq({tag, ":ab_hold"}, 32'({a_out, b_out}), 32'd3);
    check_eq({tag, ":busy_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ":ab"}, 32'({a_out, b_out}), 32'd0);
    check_eq({tag, ":busy"}, 32'(busy), 32'd0);
    check_eq({tag, ":done"}, 32'(done), 32'd0);
    check_eq({tag, ":pass"}, 32'(pass), 32'd0);
    check_eq({tag, ":err"}, 32'(err_count), 32'd0);
    check_eq({tag, ":fail"}, 32'(fail_vec), 32'd0);
  endtask

  initial begin
    int nd;
    #1;
    check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    mode = 0;
    check_result("good", 1'b0, 1'b1, 0, 7'h00);
    mode = 1;
    check_result("xor0", 1'b0, 1'b0, 2, 7'h02);
    mode = 2;
    check_result("zero", 1'b0, 1'b0, 14, 7'h7F);

    // Saturation on the narrow-counter instance.
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_eq("sat:err", 32'(err3), 32'd7);
    check_eq("sat:fail", 32'(fail3), 32'h7F);
    check_eq("sat:pass", 32'(pass3), 32'd0);

    mode = 0;
    check_result("repulse", 1'b1, 1'b1, 0, 7'h00);

    // Mid-run reset: start at T, reset low at T+6, released at T+8.
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nd = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check_eq("midrst:ab_pre", 32'({a_out, b_out}), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check_eq("midrst:no_done", 32'(nd), 32'd0);
    check_eq("midrst:err_held", 32'(err_count), 32'd0);
    mode = 0;
    check_result("after_rst", 1'b0, 1'b1, 0, 7'h00);

    mode = 3;
    check_result("nand1", 1'b0, 1'b0, 1, 7'h08);
`ifdef GATE_CHK_FIRST_FAIL_EN
    check_eq("nand1:ff_valid", 32'(ff_valid), 32'd1);
    check_eq("nand1:ff_idx", 32'(ff_idx), 32'd3);
    mode = 2;
    check_result("zero_ff", 1'b0, 1'b0, 14, 7'h7F);
    check_eq("zero_ff:ff_valid", 32'(ff_valid), 32'd1);
    check_eq("zero_ff:ff_idx", 32'(ff_idx), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
